// File: rtl/alu_branch_sequencer.sv
// ALU request sequencer: drives the external ALU, captures result/flags, resolves branches.
// Optional: define ALU_BRANCH_SEQ_SLT_EN to support set-less-than (kind 10).
module alu_branch_sequencer #(
  parameter int ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_sf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_taken,
  output logic        resp_err,
  output logic [2:0]  resp_flags
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT3 = 3'(ALU_LAT);

  state_t      state;
  state_t      state_nx;
  logic [2:0]  cnt;
  logic [1:0]  kind_q;
  logic [2:0]  f3_q;
  logic        accept;
  logic        capture;
  logic [2:0]  sel_nx;
  logic        ovf;
  logic        lt;
  logic [31:0] res_nx;
  logic        tk_nx;
  logic        err_nx;

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_nx = 3'b000;
    unique case (req_kind)
      2'b00:   sel_nx = req_funct3;
      2'b01,
      2'b10:   sel_nx = 3'b010;
      default: sel_nx = 3'b000;
    endcase
  end

  // Signed less-than from subtract flags; V from the held operands
  assign ovf = (alu_a[31] ^ alu_b[31]) & (alu_result[31] ^ alu_a[31]);
  assign lt  = alu_sf ^ ovf;

  always_comb begin
    res_nx = '0;
    tk_nx  = 1'b0;
    err_nx = 1'b0;
    unique case (kind_q)
      2'b00: begin
        res_nx = alu_result;
        err_nx = (f3_q == 3'b011);
      end
      2'b01: begin
        res_nx = alu_result;
        unique case (f3_q)
          3'b000:  tk_nx = alu_zf;
          3'b001:  tk_nx = !alu_zf;
          3'b100:  tk_nx = lt;
          3'b101:  tk_nx = !lt;
          3'b110:  tk_nx = alu_cf;
          3'b111:  tk_nx = !alu_cf;
          default: err_nx = 1'b1;
        endcase
      end
`ifdef ALU_BRANCH_SEQ_SLT_EN
      2'b10: begin
        unique case (f3_q)
          3'b010:  res_nx = {31'b0, lt};
          3'b011:  res_nx = {31'b0, alu_cf};
          default: err_nx = 1'b1;
        endcase
      end
`endif
      default: err_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      kind_q      <= '0;
      f3_q        <= '0;
      cnt         <= '0;
      resp_result <= '0;
      resp_taken  <= 1'b0;
      resp_err    <= 1'b0;
      resp_flags  <= '0;
    end else begin
      if (accept) begin
        alu_a   <= req_a;
        alu_b   <= req_b;
        alu_sel <= sel_nx;
        kind_q  <= req_kind;
        f3_q    <= req_funct3;
        cnt     <= LAT3;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        resp_result <= res_nx;
        resp_taken  <= tk_nx;
        resp_err    <= err_nx;
        resp_flags  <= {alu_cf, alu_zf, alu_sf};
      end
    end
  end

endmodule
